uart_tx_buf_serializer: RTL and testbench
=========================================

UART_TX_BUF_SERIALIZER -- requirements
Module: uart_tx_buf_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum word width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 4, width of Data_Len (>= clog2(DATA_WIDTH+1)).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-006 SHALL have port Data_Len  input  LEN_WIDTH  bit count of the word, sampled with P_DATA.
REQ-007 SHALL have port MSB_First  input  1  bit order, sampled with P_DATA (0 = LSB first).
REQ-008 SHALL have port Load  input  1  load request; accepted when Load && Load_Rdy.
REQ-009 SHALL have port Load_Rdy  output  1  holding buffer empty.
REQ-010 SHALL have port Shift_Tick  input  1  one-cycle strobe that advances one bit (baud tick).
REQ-011 SHALL have port Flush  input  1  synchronous abort of all pending and in-flight data.
REQ-012 SHALL have port ser_data  output  1  registered serial bit.
REQ-013 SHALL have port Serial_done  output  1  one-cycle pulse per completed word.
REQ-014 SHALL have port Ser_Busy  output  1  word in shifter or holding buffer.

Function
REQ-015 SHALL hold one word (data, effective length, order) in a holding buffer, with hold_valid flag; Load_Rdy = ~hold_valid, combinational.
REQ-016 On an accepted Load, SHALL capture P_DATA, Data_Len, MSB_First and set hold_valid at that edge; Load while Load_Rdy=0 is ignored.
REQ-017 Effective length SHALL be Data_Len if 1..DATA_WIDTH; Data_Len = 0 or > DATA_WIDTH SHALL be treated as DATA_WIDTH.
REQ-018 Only bits [len-1:0] of the captured word SHALL be transmitted; LSB first sends bit 0 up to bit len-1; MSB first sends bit len-1 down to bit 0.
REQ-019 FSM SHALL have states IDLE and SHIFT; reset state is IDLE.
REQ-020 IDLE with hold_valid=1: at the next edge SHALL move the word into the shifter, set remaining count = len, clear hold_valid, enter SHIFT; no Shift_Tick is required for this transfer.
REQ-021 Shift_Tick in IDLE SHALL be ignored; ser_data SHALL keep its last value in IDLE.
REQ-022 SHIFT: on each edge with Shift_Tick=1, SHALL drive the next bit onto ser_data, advance the shifter and decrement the remaining count; edges without Shift_Tick change nothing.
REQ-023 On the tick that drives the last bit (remaining count 1 to 0), Serial_done SHALL be high for exactly the following cycle.
REQ-024 On that same last-bit tick with hold_valid=1, SHALL reload the shifter from the holding buffer, clear hold_valid and stay in SHIFT, so the next tick drives the first bit of the next word with no gap.
REQ-025 On that last-bit tick with hold_valid=0, SHALL enter IDLE.
REQ-026 Load and hold consumption cannot coincide, because Load_Rdy=0 whenever hold_valid=1.
REQ-027 Ser_Busy SHALL equal (state == SHIFT) | hold_valid.
REQ-028 Flush=1 SHALL take priority over Load and Shift_Tick: clear hold_valid, shifter and count, and enter IDLE at that edge; ser_data holds its value and no Serial_done is produced.

Reset
REQ-029 RST low SHALL immediately force: state IDLE, hold_valid 0, shifter 0, count 0, ser_data 0, Serial_done 0, so Ser_Busy = 0 and Load_Rdy = 1.
REQ-030 Reset asserted mid-word SHALL discard the word; after release the block SHALL accept Load on the first edge.

Verification
REQ-031 Reset; Load P_DATA=8'hA5, len 8, LSB first; Shift_Tick every 4 cycles -> ser_data 1,0,1,0,0,1,0,1, then one Serial_done pulse in the cycle after the 8th tick, then Ser_Busy=0.
REQ-032 Load P_DATA=8'h16, len 5, MSB first -> ser_data 1,0,1,1,0; exactly 5 ticks consumed; one done pulse.
REQ-033 Load 8'h01, then Load 8'h80 during shifting; continuous ticks -> 16 bits 1,0x7,0x7,1 with no gap between words; two done pulses; Load_Rdy low from the 2nd accept until the reload tick.
REQ-034 Data_Len=0 and Data_Len=12 with DATA_WIDTH=8 -> each sends 8 bits.
REQ-035 Flush after the 3rd tick of a word, with a 2nd word held -> next cycle IDLE, Ser_Busy=0, Load_Rdy=1, no done pulse, ser_data unchanged.
REQ-036 RST low mid-word, asynchronously between edges -> ser_data, Serial_done and Ser_Busy go 0 immediately; Load_Rdy=1.

Source files
------------

// File: rtl/uart_tx_buf_serializer_if.sv
// Handshake and data bundle for uart_tx_buf_serializer.
//   master : word source / tick generator (drives P_DATA, Data_Len, MSB_First, Load,
//            Shift_Tick, Flush; observes Load_Rdy, ser_data, Serial_done, Ser_Busy)
//   slave  : the serializer itself (mirror image of master)
interface uart_tx_buf_serializer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic [LEN_WIDTH-1:0]  Data_Len;
  logic                  MSB_First;
  logic                  Load;
  logic                  Load_Rdy;
  logic                  Shift_Tick;
  logic                  Flush;
  logic                  ser_data;
  logic                  Serial_done;
  logic                  Ser_Busy;

  modport master (
    output P_DATA, Data_Len, MSB_First, Load, Shift_Tick, Flush,
    input  Load_Rdy, ser_data, Serial_done, Ser_Busy
  );

  modport slave (
    input  P_DATA, Data_Len, MSB_First, Load, Shift_Tick, Flush,
    output Load_Rdy, ser_data, Serial_done, Ser_Busy
  );
endinterface

// File: rtl/uart_tx_buf_serializer.sv
// Double-buffered parallel-to-serial shifter for a UART transmitter.
// A one-word holding buffer accepts the next word while the current one shifts out, so
// back-to-back words leave with no idle bit between them. One bit is emitted per
// Shift_Tick; word length (1..DATA_WIDTH) and bit order are captured with each word.
// Ports:
//   CLK  - single clock, all state on the rising edge
//   RST  - asynchronous active-low reset
//   bus  - slave side of uart_tx_buf_serializer_if:
//          P_DATA/Data_Len/MSB_First/Load in, Load_Rdy out (holding buffer empty),
//          Shift_Tick in (baud strobe), Flush in (synchronous abort),
//          ser_data out (registered bit), Serial_done out (1-cycle pulse per word),
//          Ser_Busy out (word in shifter or holding buffer)
module uart_tx_buf_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  uart_tx_buf_serializer_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] OneLen = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [LEN_WIDTH-1:0]  hold_len_q, hold_len_d;
  logic                  hold_msb_q, hold_msb_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  shift_msb_q, shift_msb_d;
  logic                  ser_data_q, ser_data_d;
  logic                  done_q, done_d;

  logic                  load_acc;
  logic                  take_hold;
  logic [LEN_WIDTH-1:0]  load_len;
  logic [DATA_WIDTH-1:0] hold_aligned;

  // Out-of-range lengths (0 or wider than the word) mean "full word".
  always_comb begin
    if (bus.Data_Len == '0 || bus.Data_Len > MaxLen) begin
      load_len = MaxLen;
    end else begin
      load_len = bus.Data_Len;
    end
  end

  // MSB-first words are left-aligned so bit len-1 sits at the shifter MSB and the shifter
  // always emits from a fixed end. LSB-first words need no alignment: bits above len-1
  // never reach bit 0 within len ticks.
  always_comb begin
    if (hold_msb_q) begin
      hold_aligned = hold_data_q << (DATA_WIDTH - int'(hold_len_q));
    end else begin
      hold_aligned = hold_data_q;
    end
  end

  // hold_valid is never set and consumed in the same cycle: accepting a Load needs it
  // clear, consuming the held word needs it set.
  assign load_acc = bus.Load & ~hold_valid_q;

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_len_d   = hold_len_q;
    hold_msb_d   = hold_msb_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    shift_msb_d  = shift_msb_q;
    ser_data_d   = ser_data_q;
    done_d       = 1'b0;
    take_hold    = 1'b0;

    if (bus.Flush) begin
      // Abort wins over Load and Shift_Tick; ser_data keeps its level.
      hold_valid_d = 1'b0;
      shift_d      = '0;
      cnt_d        = '0;
      state_d      = StIdle;
    end else begin
      if (load_acc) begin
        hold_valid_d = 1'b1;
        hold_data_d  = bus.P_DATA;
        hold_len_d   = load_len;
        hold_msb_d   = bus.MSB_First;
      end

      unique case (state_q)
        StIdle: begin
          // Transfer needs no tick; the first bit goes out on the next tick.
          if (hold_valid_q) begin
            take_hold = 1'b1;
            state_d   = StShift;
          end
        end
        StShift: begin
          if (bus.Shift_Tick) begin
            ser_data_d = shift_msb_q ? shift_q[DATA_WIDTH-1] : shift_q[0];
            shift_d    = shift_msb_q ? (shift_q << 1) : (shift_q >> 1);
            cnt_d      = cnt_q - OneLen;
            if (cnt_q == OneLen) begin
              done_d = 1'b1;
              // Reload on the last-bit tick so the next tick carries the next word.
              if (hold_valid_q) begin
                take_hold = 1'b1;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (take_hold) begin
        shift_d      = hold_aligned;
        cnt_d        = hold_len_q;
        shift_msb_d  = hold_msb_q;
        hold_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_len_q   <= '0;
      hold_msb_q   <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      shift_msb_q  <= 1'b0;
      ser_data_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_len_q   <= hold_len_d;
      hold_msb_q   <= hold_msb_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      shift_msb_q  <= shift_msb_d;
      ser_data_q   <= ser_data_d;
      done_q       <= done_d;
    end
  end

  assign bus.Load_Rdy    = ~hold_valid_q;
  assign bus.ser_data    = ser_data_q;
  assign bus.Serial_done = done_q;
  assign bus.Ser_Busy    = (state_q == StShift) | hold_valid_q;

endmodule

// File: tb/tb_uart_tx_buf_serializer.sv
// Self-checking bench for uart_tx_buf_serializer: a table of single-word cases plus
// hand-written back-to-back, flush and async-reset sequences. Expected serial bits are
// queued when a word is loaded and popped as each tick's bit appears.
module tb_uart_tx_buf_serializer;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_buf_serializer_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  uart_tx_buf_serializer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       msb;
    int         gap;
    logic [7:0] seq;   // expected bit k of the serial stream at seq[k]
    int         n;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  logic last_bit = 1'b0;

  always @(negedge clk) begin
    if (rst_n && bus.Serial_done === 1'b1) done_cnt++;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input logic [7:0] seq, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b    = seq[i];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Reference model of bit ordering and length clamping.
  task automatic push_word(input logic [7:0] d, input logic [3:0] l, input logic m);
    int         eff;
    logic [7:0] seq;
    eff = (l == 0 || l > 8) ? 8 : int'(l);
    seq = '0;
    for (int i = 0; i < eff; i++) seq[i] = m ? d[eff - 1 - i] : d[i];
    push_seq(seq, eff);
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic do_load(input logic [7:0] d, input logic [3:0] l, input logic m);
    int w = 0;
    while (bus.Load_Rdy !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) checkn("load_rdy_timeout", w, 0);
    bus.P_DATA    = d;
    bus.Data_Len  = l;
    bus.MSB_First = m;
    bus.Load      = 1'b1;
    @(negedge clk);
    bus.Load = 1'b0;
  endtask

  task automatic tick_once();
    exp_t e;
    bus.Shift_Tick = 1'b1;
    @(negedge clk);
    bus.Shift_Tick = 1'b0;
    if (exp_q.size() == 0) begin
      checkn("scoreboard_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check1("ser_data", bus.ser_data, e.b);
      check1("serial_done", bus.Serial_done, e.last);
      last_bit = e.b;
    end
  endtask

  task automatic tick_gap(input int gap);
    tick_once();
    repeat (gap - 1) begin
      @(negedge clk);
      check1("ser_hold", bus.ser_data, last_bit);
      check1("done_quiet", bus.Serial_done, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    bus.P_DATA = '0; bus.Data_Len = '0; bus.MSB_First = 1'b0;
    bus.Load = 1'b0; bus.Shift_Tick = 1'b0; bus.Flush = 1'b0;

    vecs[0] = '{8'hA5, 4'd8,  1'b0, 4, 8'hA5, 8};
    vecs[1] = '{8'h16, 4'd5,  1'b1, 2, 8'h0D, 5};
    vecs[2] = '{8'hC3, 4'd0,  1'b0, 1, 8'hC3, 8};
    vecs[3] = '{8'h2C, 4'd12, 1'b1, 1, 8'h34, 8};
    vecs[4] = '{8'h01, 4'd1,  1'b1, 3, 8'h01, 1};
    vecs[5] = '{8'hF9, 4'd3,  1'b0, 2, 8'h01, 3};
    vecs[6] = '{8'hF9, 4'd3,  1'b1, 2, 8'h04, 3};
    vecs[7] = '{8'h0B, 4'd7,  1'b1, 1, 8'h68, 7};

    // Reset state
    #3;
    check1("rst_ser_data", bus.ser_data, 1'b0);
    check1("rst_done", bus.Serial_done, 1'b0);
    check1("rst_busy", bus.Ser_Busy, 1'b0);
    check1("rst_load_rdy", bus.Load_Rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-word table
    for (int r = 0; r < 8; r++) begin
      do_load(vecs[r].data, vecs[r].len, vecs[r].msb);
      push_seq(vecs[r].seq, vecs[r].n);
      @(negedge clk);
      check1("busy_start", bus.Ser_Busy, 1'b1);
      d0 = done_cnt;
      for (int i = 0; i < vecs[r].n; i++) tick_gap(vecs[r].gap);
      @(negedge clk);
      check1("busy_end", bus.Ser_Busy, 1'b0);
      checkn("done_pulses_word", done_cnt - d0, 1);
    end

    // Ticks in IDLE change nothing
    d0 = done_cnt;
    repeat (3) begin
      bus.Shift_Tick = 1'b1;
      @(negedge clk);
      bus.Shift_Tick = 1'b0;
      check1("idle_tick_ser", bus.ser_data, last_bit);
      check1("idle_tick_busy", bus.Ser_Busy, 1'b0);
    end
    checkn("idle_tick_done", done_cnt - d0, 0);

    // Back-to-back words, second loaded while the first shifts
    do_load(8'h01, 4'd8, 1'b0);
    push_word(8'h01, 4'd8, 1'b0);
    @(negedge clk);
    d0 = done_cnt;
    bus.P_DATA = 8'h80; bus.Data_Len = 4'd8; bus.MSB_First = 1'b0; bus.Load = 1'b1;
    push_word(8'h80, 4'd8, 1'b0);
    tick_once();
    bus.Load = 1'b0;
    check1("rdy_low_after_2nd", bus.Load_Rdy, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      tick_once();
      if (k < 8) check1("rdy_low_held", bus.Load_Rdy, 1'b0);
    end
    check1("rdy_after_reload", bus.Load_Rdy, 1'b1);
    check1("busy_after_reload", bus.Ser_Busy, 1'b1);
    for (int k = 0; k < 8; k++) tick_once();
    @(negedge clk);
    checkn("done_pulses_b2b", done_cnt - d0, 2);
    check1("busy_after_b2b", bus.Ser_Busy, 1'b0);

    // Flush mid-word with a second word held
    do_load(8'h0F, 4'd8, 1'b0);
    push_word(8'h0F, 4'd8, 1'b0);
    @(negedge clk);
    repeat (3) tick_gap(1);
    do_load(8'h55, 4'd8, 1'b0);
    check1("flush_pre_rdy", bus.Load_Rdy, 1'b0);
    check1("flush_pre_busy", bus.Ser_Busy, 1'b1);
    d0 = done_cnt;
    bus.Flush = 1'b1;
    bus.Shift_Tick = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    bus.Shift_Tick = 1'b0;
    exp_q.delete();
    check1("flush_busy", bus.Ser_Busy, 1'b0);
    check1("flush_rdy", bus.Load_Rdy, 1'b1);
    check1("flush_done", bus.Serial_done, 1'b0);
    check1("flush_ser_hold", bus.ser_data, 1'b1);
    repeat (3) @(negedge clk);
    checkn("flush_no_done", done_cnt - d0, 0);
    check1("flush_stays_idle", bus.Ser_Busy, 1'b0);

    // Asynchronous reset mid-word, then load on the first edge after release
    do_load(8'hFF, 4'd8, 1'b0);
    push_word(8'hFF, 4'd8, 1'b0);
    @(negedge clk);
    repeat (3) tick_gap(1);
    check1("pre_rst_ser", bus.ser_data, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check1("arst_ser", bus.ser_data, 1'b0);
    check1("arst_done", bus.Serial_done, 1'b0);
    check1("arst_busy", bus.Ser_Busy, 1'b0);
    check1("arst_rdy", bus.Load_Rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.P_DATA = 8'h96; bus.Data_Len = 4'd8; bus.MSB_First = 1'b1; bus.Load = 1'b1;
    push_word(8'h96, 4'd8, 1'b1);
    @(negedge clk);
    bus.Load = 1'b0;
    check1("load_first_edge", bus.Load_Rdy, 1'b0);
    @(negedge clk);
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) tick_once();
    @(negedge clk);
    checkn("done_after_reset", done_cnt - d0, 1);
    check1("busy_after_reset_word", bus.Ser_Busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
